// File: rtl/dual_fetch_unit_pkg.sv
// Shared definitions for the dual-issue fetch unit: widths, opcode
// constants, predictor geometry, FSM state encoding and small helpers.
package dual_fetch_unit_pkg;

    localparam int PC_W     = 8;
    localparam int INST_W   = 32;
    localparam int CNT_W    = 2;
    localparam int BP_DEPTH = 16;
    localparam int BP_IDX_W = 4;

    localparam logic [5:0]       OP_BEQ   = 6'h04;
    localparam logic [5:0]       OP_BNE   = 6'h05;
    localparam logic [CNT_W-1:0] CNT_INIT = 2'b01;  // weakly not-taken
    localparam logic [CNT_W-1:0] CNT_MAX  = 2'b11;
    localparam logic [CNT_W-1:0] CNT_MIN  = 2'b00;

    typedef enum logic [0:0] {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } fetch_state_e;

    // A slot is a conditional branch when its opcode is BEQ or BNE.
    function automatic logic is_branch(input logic [INST_W-1:0] inst);
        return (inst[31:26] == OP_BEQ) || (inst[31:26] == OP_BNE);
    endfunction

    // Two-bit saturating counter step.
    function automatic logic [CNT_W-1:0] sat_step(input logic [CNT_W-1:0] cnt,
                                                  input logic             taken);
        logic [CNT_W-1:0] res;
        res = cnt;
        if (taken && (cnt != CNT_MAX)) begin
            res = cnt + 2'd1;
        end else if (!taken && (cnt != CNT_MIN)) begin
            res = cnt - 2'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/dual_fetch_unit_bpred.sv
// bpred_table: 16-entry table of 2-bit saturating counters, two read ports
// for the two fetch slots and one training write port.
// Storage exists only when DUAL_FETCH_BPRED_EN is defined; otherwise both
// read ports return 0 (never predict taken) and training is ignored.
module bpred_table
    import dual_fetch_unit_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic [BP_IDX_W-1:0] rd_idx1_i,
    input  logic [BP_IDX_W-1:0] rd_idx2_i,
    output logic [CNT_W-1:0]    rd_cnt1_o,
    output logic [CNT_W-1:0]    rd_cnt2_o,
    input  logic                wr_valid_i,
    input  logic [BP_IDX_W-1:0] wr_idx_i,
    input  logic                wr_taken_i
);

`ifdef DUAL_FETCH_BPRED_EN
    logic [CNT_W-1:0] cnt_q [BP_DEPTH];
    logic [CNT_W-1:0] cnt_d;

    // Next value of the entry being trained.
    always_comb begin
        cnt_d = sat_step(cnt_q[wr_idx_i], wr_taken_i);
    end

    // Counter storage; a write lands on the next edge, so a same-cycle
    // lookup of the trained entry still sees the old value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < BP_DEPTH; i++) begin
                cnt_q[i] <= CNT_INIT;
            end
        end else if (wr_valid_i) begin
            cnt_q[wr_idx_i] <= cnt_d;
        end
    end

    assign rd_cnt1_o = cnt_q[rd_idx1_i];
    assign rd_cnt2_o = cnt_q[rd_idx2_i];
`else
    logic unused_ports;
    assign unused_ports = ^{clk, reset, rd_idx1_i, rd_idx2_i, wr_valid_i, wr_idx_i, wr_taken_i};
    assign rd_cnt1_o    = CNT_MIN;
    assign rd_cnt2_o    = CNT_MIN;
`endif

endmodule

// File: rtl/dual_fetch_unit.sv
// dual_fetch_unit: fetches two consecutive instructions per cycle, predicts
// BEQ/BNE in either slot and selects the next PC. A one-cycle BOOT state
// after reset flushes both slots before normal operation.
// Branch prediction is enabled with DUAL_FETCH_BPRED_EN (inside bpred_table).
module dual_fetch_unit
    import dual_fetch_unit_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              stall_outer,
    input  logic              redirect_valid,
    input  logic [PC_W-1:0]   redirect_pc,
    input  logic              bp_update_valid,
    input  logic [PC_W-1:0]   bp_update_pc,
    input  logic              bp_update_taken,
    output logic [PC_W-1:0]   imem_addr1,
    output logic [PC_W-1:0]   imem_addr2,
    input  logic [INST_W-1:0] imem_data1,
    input  logic [INST_W-1:0] imem_data2,
    output logic [INST_W-1:0] inst1_Fetch,
    output logic [INST_W-1:0] inst2_Fetch,
    output logic [PC_W-1:0]   pcF,
    output logic [PC_W-1:0]   pcPlus1F,
    output logic [PC_W-1:0]   pcPlus2_F,
    output logic [PC_W-1:0]   pcBranchF,
    output logic [PC_W-1:0]   pcBranchF_inst2,
    output logic              predictionF_1,
    output logic              predictionF_2,
    output logic              flush_F_1,
    output logic              flush_F_2,
    output fetch_state_e      fsm_state_o
);

    logic [PC_W-1:0]  pc_q, pc_d;
    fetch_state_e     state_q, state_d;
    logic [CNT_W-1:0] cnt1, cnt2;
    logic             unused_upd_pc;

    assign unused_upd_pc = ^bp_update_pc[PC_W-1:BP_IDX_W];

    // Sequential PC arithmetic wraps modulo 256.
    assign pcF       = pc_q;
    assign pcPlus1F  = pc_q + 8'd1;
    assign pcPlus2_F = pc_q + 8'd2;

    assign imem_addr1  = pcF;
    assign imem_addr2  = pcPlus1F;
    assign inst1_Fetch = imem_data1;
    assign inst2_Fetch = imem_data2;

    // Low byte of the instruction is the offset; 8-bit add truncates the
    // sign extension naturally.
    assign pcBranchF       = pcPlus1F + inst1_Fetch[7:0];
    assign pcBranchF_inst2 = pcPlus2_F + inst2_Fetch[7:0];

    bpred_table u_bpred (
        .clk        (clk),
        .reset      (reset),
        .rd_idx1_i  (pcF[BP_IDX_W-1:0]),
        .rd_idx2_i  (pcPlus1F[BP_IDX_W-1:0]),
        .rd_cnt1_o  (cnt1),
        .rd_cnt2_o  (cnt2),
        .wr_valid_i (bp_update_valid),
        .wr_idx_i   (bp_update_pc[BP_IDX_W-1:0]),
        .wr_taken_i (bp_update_taken)
    );

    assign predictionF_1 = is_branch(inst1_Fetch) & cnt1[1];
    assign predictionF_2 = is_branch(inst2_Fetch) & cnt2[1];

    assign fsm_state_o = state_q;

    // Slot flushes, next-PC selection and FSM advance. BOOT flushes both
    // slots and holds the PC; in RUN a redirect beats a stall.
    always_comb begin
        pc_d      = pc_q;
        state_d   = state_q;
        flush_F_1 = 1'b1;
        flush_F_2 = 1'b1;
        if (state_q == ST_BOOT) begin
            state_d = ST_RUN;
        end else begin
            flush_F_1 = redirect_valid;
            flush_F_2 = redirect_valid | predictionF_1;
            if (redirect_valid) begin
                pc_d = redirect_pc;
            end else if (stall_outer) begin
                pc_d = pc_q;
            end else if (predictionF_1) begin
                pc_d = pcBranchF;
            end else if (predictionF_2) begin
                pc_d = pcBranchF_inst2;
            end else begin
                pc_d = pcPlus2_F;
            end
        end
    end

    // PC and FSM registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q    <= '0;
            state_q <= ST_BOOT;
        end else begin
            pc_q    <= pc_d;
            state_q <= state_d;
        end
    end

endmodule
